mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 14, memory block address width (16-bit word address bits [15:2]).
REQ-002 Parameter: DATA_W, 64, block width (four 16-bit words).
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: i_req  in  1  I-cache miss fill request; held high until i_done.
REQ-006 Port: i_addr  in  ADDR_W  I-cache fill block address; stable while i_req high.
REQ-007 Port: d_req  in  1  D-cache miss request; held high until d_done.
REQ-008 Port: d_wb  in  1  victim dirty, write-back required first; stable while d_req high.
REQ-009 Port: d_addr / d_wb_addr  in  ADDR_W each  D fill address / victim address.
REQ-010 Port: d_wb_data  in  DATA_W  victim block data.
REQ-011 Port: mem_addr  out  ADDR_W; mem_re, mem_we  out  1 each; mem_wdata  out  DATA_W.
REQ-012 Port: mem_rdata  in  DATA_W; memrdy  in  1  one-cycle pulse, operation complete.
REQ-013 Port: fill_data  out  DATA_W  registered mem_rdata captured on fill memrdy.
REQ-014 Port: i_done, d_done  out  1 each  one-cycle completion pulse; doubles as cache fill write enable.
REQ-015 Port: owner  out  1  0 = I side owns memory, 1 = D side.

Function
REQ-016 FSM states SHALL be IDLE, D_WB, D_FILL, I_FILL, RESP; state register only, outputs decoded from state.
REQ-017 IDLE: d_req selected -> D_WB if d_wb=1 else D_FILL; i_req selected -> I_FILL; no request -> stay.
REQ-018 Both requests in same IDLE cycle: D side wins (fixed priority; see REQ-031 for alternative).
REQ-019 D_WB: mem_we=1, mem_addr=d_wb_addr, mem_wdata=d_wb_data; on memrdy -> D_FILL.
REQ-020 D_FILL: mem_re=1, mem_addr=d_addr; on memrdy capture fill_data, -> RESP.
REQ-021 I_FILL: mem_re=1, mem_addr=i_addr; on memrdy capture fill_data, -> RESP.
REQ-022 RESP: mem_re=mem_we=0; exactly one of i_done/d_done=1 per served side; -> IDLE next cycle.
REQ-023 mem_re and mem_we SHALL never be high together, and SHALL be low at least one cycle between consecutive memory operations, including D_WB->D_FILL (insert one bubble cycle with both low before D_FILL asserts mem_re).
REQ-024 owner SHALL be 1 in D_WB/D_FILL and in RESP after a D transaction, 0 otherwise; registered, updated on grant.
REQ-025 Latency: request sampled in IDLE at edge N -> mem op asserted cycle N+1; done asserted the cycle after memrdy.
REQ-026 Requests sampled only in IDLE; a req dropped mid-transaction SHALL NOT abort it; done still pulses.
REQ-027 memrdy outside D_WB/D_FILL/I_FILL SHALL be ignored; no state change, fill_data unchanged.
REQ-028 Outside D_WB, mem_wdata SHALL be 0; outside active states mem_addr SHALL be 0.

Reset
REQ-029 rst_n low: state=IDLE, owner=0, fill_data=0, all outputs 0, round-robin pointer (if built) = I-next; applies immediately, mid-transaction included.
REQ-030 A transaction interrupted by reset SHALL produce no done pulse; requesters re-request after reset release.

Configuration
REQ-031 Macro ARB_RR_EN defined: simultaneous requests served round-robin via 1-bit last-served register (serve side not served last; updated on each grant); undefined: fixed D priority per REQ-018, register absent.

Verification
REQ-032 i_req=1, i_addr=14'h0012, memrdy 4 cycles after mem_re -> mem_re high 4 cycles, fill_data=mem_rdata, i_done pulse 1 cycle, owner=0.
REQ-033 d_req=1, d_wb=1, d_wb_addr=14'h0100, d_addr=14'h0200 -> mem_we with addr 0x0100, one bubble cycle, mem_re with addr 0x0200, d_done once, owner=1 throughout.
REQ-034 i_req and d_req rise same cycle, ARB_RR_EN undefined -> D served first, I second; defined, after reset -> I first, then D; repeat -> alternation.
REQ-035 Assert rst_n=0 two cycles into D_WB -> mem_we drops asynchronously, no d_done, state IDLE after release.
REQ-036 Spurious memrdy pulse in IDLE and d_req dropped during D_FILL -> no state change / d_done still pulses once.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between I-cache fills and D-cache write-back/fill sequences.
// Optional macro ARB_RR_EN: round-robin between simultaneous requests instead of fixed D priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_wb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_wb_addr,
    input  logic [DATA_W-1:0] d_wb_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              memrdy,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_done,
    output logic              d_done,
    output logic              owner,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_WB   = 3'd1,
        D_FILL = 3'd2,
        I_FILL = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Handshake: i_req/d_req are level requests held until the matching *_done
    // pulse; memrdy is a one-cycle completion pulse honoured only while mem_re or
    // mem_we is high.
    state_t state, state_nxt;
    logic   owner_q, owner_nxt;
    logic   bubble_q, bubble_nxt;
    logic   fill_en;
    logic   grant_d;
    logic [DATA_W-1:0] fill_q;

`ifdef ARB_RR_EN
    // last_d_q = 1 means D was served last, so I goes next on a tie.
    logic last_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_d_q <= 1'b1;
        else if (state == IDLE && (i_req || d_req))
            last_d_q <= grant_d;
    end

    assign grant_d = d_req && (!i_req || !last_d_q);
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner_q  <= 1'b0;
            bubble_q <= 1'b0;
            fill_q   <= '0;
        end else begin
            state    <= state_nxt;
            owner_q  <= owner_nxt;
            bubble_q <= bubble_nxt;
            if (fill_en)
                fill_q <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner_q;
        bubble_nxt = bubble_q;
        fill_en    = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        case (state)
            IDLE: begin
                owner_nxt  = 1'b0;
                bubble_nxt = 1'b0;
                if (grant_d) begin
                    owner_nxt = 1'b1;
                    state_nxt = d_wb ? D_WB : D_FILL;
                end else if (i_req) begin
                    state_nxt = I_FILL;
                end
            end
            D_WB: begin
                mem_we    = 1'b1;
                mem_addr  = d_wb_addr;
                mem_wdata = d_wb_data;
                if (memrdy) begin
                    state_nxt  = D_FILL;
                    bubble_nxt = 1'b1;
                end
            end
            D_FILL: begin
                // First D_FILL cycle after a write-back keeps the port idle.
                if (bubble_q) begin
                    bubble_nxt = 1'b0;
                end else begin
                    mem_re   = 1'b1;
                    mem_addr = d_addr;
                    if (memrdy) begin
                        fill_en   = 1'b1;
                        state_nxt = RESP;
                    end
                end
            end
            I_FILL: begin
                mem_re   = 1'b1;
                mem_addr = i_addr;
                if (memrdy) begin
                    fill_en   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                i_done    = !owner_q;
                d_done    = owner_q;
                owner_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fill_data = fill_q;
    assign owner     = owner_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table for I fill / D write-back+fill,
// plus hand sequences for simultaneous requests and reset during write-back.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 64;

    localparam logic [ADDR_W-1:0] IA = 14'h0012;
    localparam logic [ADDR_W-1:0] DA = 14'h0200;
    localparam logic [ADDR_W-1:0] WA = 14'h0100;
    localparam logic [DATA_W-1:0] WD = 64'hDEAD_BEEF_0123_4567;
    localparam logic [DATA_W-1:0] R1 = 64'h1111_2222_3333_4444;
    localparam logic [DATA_W-1:0] R2 = 64'hAAAA_BBBB_CCCC_DDDD;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = IA;
    logic              d_req = 1'b0;
    logic              d_wb = 1'b0;
    logic [ADDR_W-1:0] d_addr = DA;
    logic [ADDR_W-1:0] d_wb_addr = WA;
    logic [DATA_W-1:0] d_wb_data = WD;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              memrdy = 1'b0;
    logic [DATA_W-1:0] fill_data;
    logic              i_done;
    logic              d_done;
    logic              owner;
    logic [2:0]        dbg_state;

    int n_checks = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wb(d_wb), .d_addr(d_addr),
        .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .memrdy(memrdy),
        .fill_data(fill_data), .i_done(i_done), .d_done(d_done),
        .owner(owner), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              i_req;
        logic              d_req;
        logic              d_wb;
        logic              memrdy;
        logic [DATA_W-1:0] rdata;
        logic              e_re;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic              e_idone;
        logic              e_ddone;
        logic              e_owner;
        logic [DATA_W-1:0] e_fill;
        logic [2:0]        e_state;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        i_req  = 1'b0;
        d_req  = 1'b0;
        d_wb   = 1'b0;
        memrdy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // The port must never read and write in the same cycle.
    always @(negedge clk) begin
        if (rst_n)
            check("re_we_exclusive", {63'd0, mem_re & mem_we}, 64'd0);
    end

    // Serve one pending transaction: wait for a read, pulse memrdy, report which side finished.
    task automatic serve(input string tag, output logic got_d);
        int n;
        got_d = 1'b0;
        n = 0;
        while (!mem_re && n < 20) begin
            tick();
            n++;
        end
        check({tag, " op_started"}, {63'd0, mem_re}, 64'd1);
        mem_rdata = R1;
        memrdy = 1'b1;
        tick();
        memrdy = 1'b0;
        check({tag, " one_done"}, {63'd0, i_done ^ d_done}, 64'd1);
        got_d = d_done;
        if (d_done)
            d_req = 1'b0;
        if (i_done)
            i_req = 1'b0;
        tick();
    endtask

    vec_t vecs[15];

    initial begin
        logic got_d;
        logic first_d;
        int   hit;

        // i,d,wb,rdy,rdata | re,we,addr,idone,ddone,owner,fill,state
        vecs[0]  = '{1,0,0,0,R1, 1,0,IA,0,0,0,64'd0,3'd3};
        vecs[1]  = '{1,0,0,0,R1, 1,0,IA,0,0,0,64'd0,3'd3};
        vecs[2]  = '{1,0,0,0,R1, 1,0,IA,0,0,0,64'd0,3'd3};
        vecs[3]  = '{1,0,0,0,R1, 1,0,IA,0,0,0,64'd0,3'd3};
        vecs[4]  = '{1,0,0,1,R1, 0,0,14'd0,1,0,0,R1,3'd4};
        vecs[5]  = '{0,0,0,0,R1, 0,0,14'd0,0,0,0,R1,3'd0};
        vecs[6]  = '{0,1,1,0,R1, 0,1,WA,0,0,1,R1,3'd1};
        vecs[7]  = '{0,1,1,0,R1, 0,1,WA,0,0,1,R1,3'd1};
        vecs[8]  = '{0,1,1,1,R1, 0,0,14'd0,0,0,1,R1,3'd2};
        vecs[9]  = '{0,1,1,0,R1, 1,0,DA,0,0,1,R1,3'd2};
        vecs[10] = '{0,0,1,0,R2, 1,0,DA,0,0,1,R1,3'd2};
        vecs[11] = '{0,0,1,1,R2, 0,0,14'd0,0,1,1,R2,3'd4};
        vecs[12] = '{0,0,0,0,R2, 0,0,14'd0,0,0,0,R2,3'd0};
        vecs[13] = '{0,0,0,1,R1, 0,0,14'd0,0,0,0,R2,3'd0};
        vecs[14] = '{0,0,0,0,R1, 0,0,14'd0,0,0,0,R2,3'd0};

        do_reset();
        check("rst re", {63'd0, mem_re}, 64'd0);
        check("rst we", {63'd0, mem_we}, 64'd0);
        check("rst addr", {50'd0, mem_addr}, 64'd0);
        check("rst owner", {63'd0, owner}, 64'd0);
        check("rst fill", fill_data, 64'd0);
        check("rst state", {61'd0, dbg_state}, 64'd0);

        for (int i = 0; i < 15; i++) begin
            i_req     = vecs[i].i_req;
            d_req     = vecs[i].d_req;
            d_wb      = vecs[i].d_wb;
            memrdy    = vecs[i].memrdy;
            mem_rdata = vecs[i].rdata;
            tick();
            check($sformatf("row%0d re", i), {63'd0, mem_re}, {63'd0, vecs[i].e_re});
            check($sformatf("row%0d we", i), {63'd0, mem_we}, {63'd0, vecs[i].e_we});
            check($sformatf("row%0d addr", i), {50'd0, mem_addr}, {50'd0, vecs[i].e_addr});
            check($sformatf("row%0d wdata", i), mem_wdata, vecs[i].e_we ? WD : 64'd0);
            check($sformatf("row%0d i_done", i), {63'd0, i_done}, {63'd0, vecs[i].e_idone});
            check($sformatf("row%0d d_done", i), {63'd0, d_done}, {63'd0, vecs[i].e_ddone});
            check($sformatf("row%0d owner", i), {63'd0, owner}, {63'd0, vecs[i].e_owner});
            check($sformatf("row%0d fill", i), fill_data, vecs[i].e_fill);
            check($sformatf("row%0d state", i), {61'd0, dbg_state}, {61'd0, vecs[i].e_state});
        end
        memrdy = 1'b0;

        // Simultaneous requests, two rounds, starting from reset.
`ifdef ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        do_reset();
        for (int r = 0; r < 2; r++) begin
            i_req = 1'b1;
            d_req = 1'b1;
            d_wb  = 1'b0;
            for (int k = 0; k < 2; k++) begin
                serve($sformatf("tie r%0d k%0d", r, k), got_d);
                check($sformatf("tie r%0d k%0d side", r, k), {63'd0, got_d},
                      {63'd0, (k == 0) ? first_d : !first_d});
            end
        end

        // Reset asserted two cycles into a write-back.
        do_reset();
        d_req = 1'b1;
        d_wb  = 1'b1;
        tick();
        check("wbrst we_on", {63'd0, mem_we}, 64'd1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("wbrst we_async_drop", {63'd0, mem_we}, 64'd0);
        check("wbrst state_async", {61'd0, dbg_state}, 64'd0);
        d_req = 1'b0;
        d_wb  = 1'b0;
        hit = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (d_done || i_done)
                hit++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (d_done || i_done)
                hit++;
        end
        check("wbrst no_done", hit, 64'd0);
        check("wbrst state_idle", {61'd0, dbg_state}, 64'd0);
        check("wbrst owner", {63'd0, owner}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
